// File: rtl/pipe_pkg.sv
// pipe_pkg: occupancy states, per-stage payload layouts and bubble encodings shared by the pipeline registers
package pipe_pkg;

    // Occupancy of a skid stage doubles as its state encoding
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    localparam int XLEN    = 32;
    localparam int ICODE_W = 6;

    // The MIPS nop is sll $0,$0,0, which encodes as all zeros
    localparam logic [XLEN-1:0]    NOP_INSTR = 32'h0000_0000;
    localparam logic [ICODE_W-1:0] ICODE_NOP = 6'd0;

    // ID/EX payload: {icode, imm, rt_val, rs_val, instr, pc}
    localparam int ID_EX_PC_LSB    = 0;
    localparam int ID_EX_INSTR_LSB = ID_EX_PC_LSB + XLEN;
    localparam int ID_EX_RS_LSB    = ID_EX_INSTR_LSB + XLEN;
    localparam int ID_EX_RT_LSB    = ID_EX_RS_LSB + XLEN;
    localparam int ID_EX_IMM_LSB   = ID_EX_RT_LSB + XLEN;
    localparam int ID_EX_ICODE_LSB = ID_EX_IMM_LSB + XLEN;
    localparam int ID_EX_W         = ID_EX_ICODE_LSB + ICODE_W;

    // EX/MEM payload: {icode, store_val, alu_out, pc}
    localparam int EX_MEM_PC_LSB    = 0;
    localparam int EX_MEM_ALU_LSB   = EX_MEM_PC_LSB + XLEN;
    localparam int EX_MEM_STORE_LSB = EX_MEM_ALU_LSB + XLEN;
    localparam int EX_MEM_ICODE_LSB = EX_MEM_STORE_LSB + XLEN;
    localparam int EX_MEM_W         = EX_MEM_ICODE_LSB + ICODE_W;

    // MEM/WB payload: {icode, result, pc}
    localparam int MEM_WB_PC_LSB    = 0;
    localparam int MEM_WB_RES_LSB   = MEM_WB_PC_LSB + XLEN;
    localparam int MEM_WB_ICODE_LSB = MEM_WB_RES_LSB + XLEN;
    localparam int MEM_WB_W         = MEM_WB_ICODE_LSB + ICODE_W;

    // Bubble payloads: nop instruction and icode, PC and operand fields zero
    function automatic logic [ID_EX_W-1:0] id_ex_bubble();
        logic [ID_EX_W-1:0] b;
        b = '0;
        b[ID_EX_INSTR_LSB +: XLEN]    = NOP_INSTR;
        b[ID_EX_ICODE_LSB +: ICODE_W] = ICODE_NOP;
        return b;
    endfunction

    function automatic logic [EX_MEM_W-1:0] ex_mem_bubble();
        logic [EX_MEM_W-1:0] b;
        b = '0;
        b[EX_MEM_ICODE_LSB +: ICODE_W] = ICODE_NOP;
        return b;
    endfunction

    function automatic logic [MEM_WB_W-1:0] mem_wb_bubble();
        logic [MEM_WB_W-1:0] b;
        b = '0;
        b[MEM_WB_ICODE_LSB +: ICODE_W] = ICODE_NOP;
        return b;
    endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// pipe_data_reg: enable register with async reset-to-constant and synchronous clear to the same constant
module pipe_data_reg #(
    parameter int              DATA_W  = 166,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              clr,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] data_q, data_d;

    // Clear beats load so a flush always leaves the reset constant behind
    always_comb begin
        data_d = clr ? RST_VAL : (en ? d : data_q);
    end

    // Storage flop, forced to the constant immediately on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) data_q <= RST_VAL;
        else       data_q <= data_d;
    end

    assign q = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline register with a two-entry skid buffer and synchronous flush
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = 166,
    parameter logic [DATA_W-1:0] BUBBLE_DATA = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    occ_e              state_q, state_d;
    logic              in_fire, out_fire;
    logic              main_en, main_clr, main_from_skid, skid_en;
    logic [DATA_W-1:0] main_d, skid_q;

    // Handshake flags come straight from the state flop, so out_ready never reaches in_ready
    assign in_ready  = (state_q != OCC_FULL);
    assign out_valid = (state_q != OCC_EMPTY);
    assign occupancy = state_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign main_d    = main_from_skid ? skid_q : in_data;

    // Next state and register steering; flush overrides everything and empties the stage
    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_en        = 1'b0;
        if (flush) begin
            state_d  = OCC_EMPTY;
            main_clr = 1'b1;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    state_d = in_fire ? OCC_ONE : OCC_EMPTY;
                    main_en = in_fire;
                end
                OCC_ONE: begin
                    state_d  = (in_fire && !out_fire) ? OCC_FULL :
                               (!in_fire && out_fire) ? OCC_EMPTY : OCC_ONE;
                    main_en  = in_fire & out_fire;
                    skid_en  = in_fire & ~out_fire;
                    main_clr = ~in_fire & out_fire;
                end
                OCC_FULL: begin
                    state_d        = out_fire ? OCC_ONE : OCC_FULL;
                    main_en        = out_fire;
                    main_from_skid = 1'b1;
                end
                default: begin
                    state_d  = OCC_EMPTY;
                    main_clr = 1'b1;
                end
            endcase
        end
    end

    // State register; reset empties the stage at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= OCC_EMPTY;
        else       state_q <= state_d;
    end

    pipe_data_reg #(
        .DATA_W (DATA_W),
        .RST_VAL(BUBBLE_DATA)
    ) u_main (
        .clk  (clk),
        .reset(reset),
        .en   (main_en),
        .clr  (main_clr),
        .d    (main_d),
        .q    (out_data)
    );

    pipe_data_reg #(
        .DATA_W (DATA_W),
        .RST_VAL(BUBBLE_DATA)
    ) u_skid (
        .clk  (clk),
        .reset(reset),
        .en   (skid_en),
        .clr  (1'b0),
        .d    (in_data),
        .q    (skid_q)
    );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: directed vectors plus a scoreboarded random soak for pipe_stage_skid
module tb_pipe_stage_skid;

    localparam int          W      = 16;
    localparam logic [W-1:0] BUBBLE = 16'hDEAD;

    logic         clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] in_data, out_data;
    logic [1:0]   occupancy;
    int           errors = 0;
    int           checks = 0;

    pipe_stage_skid #(.DATA_W(W), .BUBBLE_DATA(BUBBLE)) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [W-1:0] id, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic ov, input logic [W-1:0] od,
                              input logic [1:0] occ, input logic ir);
        check({tag, ".valid"}, 32'(out_valid), 32'(ov));
        check({tag, ".data"}, 32'(out_data), 32'(od));
        check({tag, ".occ"}, 32'(occupancy), 32'(occ));
        check({tag, ".ready"}, 32'(in_ready), 32'(ir));
    endtask

    logic [W-1:0] sb[$];
    logic         fire_i, fire_o;

    initial begin
        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        tick();
        expect_out("rst_hold", 1'b0, BUBBLE, 2'd0, 1'b1);
        reset = 1'b0;
        tick();
        expect_out("idle", 1'b0, BUBBLE, 2'd0, 1'b1);

        // async reset mid-cycle while FULL
        drive(1'b1, 16'h00A5, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h005A, 1'b0, 1'b0);
        tick();
        expect_out("pre_rst", 1'b1, 16'h00A5, 2'd2, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        expect_out("async_rst", 1'b0, BUBBLE, 2'd0, 1'b1);
        #1 reset = 1'b0;
        tick();
        expect_out("post_rst", 1'b0, BUBBLE, 2'd0, 1'b1);

        // streaming 1..4
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, W'(i), 1'b1, 1'b0);
            check("stream.ready", 32'(in_ready), 32'd1);
            tick();
            expect_out($sformatf("stream%0d", i), 1'b1, W'(i), 2'd1, 1'b1);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        expect_out("stream_drain", 1'b0, BUBBLE, 2'd0, 1'b1);

        // downstream stall
        drive(1'b1, 16'd10, 1'b1, 1'b0);
        tick();
        expect_out("stall_a", 1'b1, 16'd10, 2'd1, 1'b1);
        drive(1'b1, 16'd11, 1'b0, 1'b0);
        tick();
        expect_out("stall_b", 1'b1, 16'd10, 2'd2, 1'b0);
        drive(1'b1, 16'd12, 1'b0, 1'b0);
        tick();
        expect_out("stall_c", 1'b1, 16'd10, 2'd2, 1'b0);
        tick();
        expect_out("stall_d", 1'b1, 16'd10, 2'd2, 1'b0);
        drive(1'b1, 16'd12, 1'b1, 1'b0);
        tick();
        expect_out("stall_e", 1'b1, 16'd11, 2'd1, 1'b1);
        tick();
        expect_out("stall_f", 1'b1, 16'd12, 2'd1, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        expect_out("stall_g", 1'b0, BUBBLE, 2'd0, 1'b1);

        // flush while FULL
        drive(1'b1, 16'd20, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'd21, 1'b0, 1'b0);
        tick();
        expect_out("fl_full", 1'b1, 16'd20, 2'd2, 1'b0);
        drive(1'b1, 16'd22, 1'b0, 1'b1);
        tick();
        expect_out("fl_after", 1'b0, BUBBLE, 2'd0, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        expect_out("fl_quiet", 1'b0, BUBBLE, 2'd0, 1'b1);

        // flush in ONE discards a simultaneous in_fire
        drive(1'b1, 16'd23, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'd24, 1'b1, 1'b1);
        tick();
        expect_out("fl_one", 1'b0, BUBBLE, 2'd0, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        expect_out("fl_one_q", 1'b0, BUBBLE, 2'd0, 1'b1);

        // simultaneous in/out in ONE
        drive(1'b1, 16'd30, 1'b0, 1'b0);
        tick();
        expect_out("pass_a", 1'b1, 16'd30, 2'd1, 1'b1);
        drive(1'b1, 16'd31, 1'b1, 1'b0);
        tick();
        expect_out("pass_b", 1'b1, 16'd31, 2'd1, 1'b1);
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        expect_out("pass_c", 1'b0, BUBBLE, 2'd0, 1'b1);

        // random soak against a FIFO scoreboard
        sb.delete();
        for (int c = 0; c < 10000; c++) begin
            drive(1'($urandom_range(1)), W'($urandom), 1'($urandom_range(1)),
                  $urandom_range(99) < 5);
            if (out_valid !== (sb.size() > 0) || occupancy !== 2'(sb.size())
                || in_ready !== (sb.size() < 2)
                || out_data !== ((sb.size() > 0) ? sb[0] : BUBBLE))
                expect_out($sformatf("soak%0d", c), sb.size() > 0,
                           (sb.size() > 0) ? sb[0] : BUBBLE, 2'(sb.size()), sb.size() < 2);
            else
                checks++;
            fire_i = in_valid & (sb.size() < 2);
            fire_o = out_ready & (sb.size() > 0);
            @(posedge clk);
            if (flush) sb.delete();
            else begin
                if (fire_o) void'(sb.pop_front());
                if (fire_i) sb.push_back(in_data);
            end
            #1;
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) tick();
        expect_out("soak_end", 1'b0, BUBBLE, 2'd0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
